memory_stage_unit: RTL

Memory stage of the five-stage pipeline. It sits directly downstream of the Execute/Memory pipeline register and consumes that register's memory-access controls, effective address and store data. It owns the data memory, performs single-word (16-bit) and wide (32-bit, two-word) reads and writes, and drives the stall back to the upstream stages while a wide access is in progress. Results go to the Memory/Write-back pipeline register.

---
 rtl/memory_stage_unit_if.sv | 37 +++
 rtl/memory_stage_unit.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage_unit_if.sv
// Memory-stage bundle: EM-register access controls in, load data,
// completion/error pulses and stall back out.
interface memory_stage_unit_if;
  logic        mem_read_IN;
  logic        mem_write_IN;
  logic        mem_wide_IN;
  logic [15:0] address_IN;
  logic [31:0] write_data_IN;
  logic [31:0] read_data_OUT;
  logic        valid_OUT;
  logic        error_OUT;
  logic        stall_OUT;

  modport master (
    output mem_read_IN,
    output mem_write_IN,
    output mem_wide_IN,
    output address_IN,
    output write_data_IN,
    input  read_data_OUT,
    input  valid_OUT,
    input  error_OUT,
    input  stall_OUT
  );

  modport slave (
    input  mem_read_IN,
    input  mem_write_IN,
    input  mem_wide_IN,
    input  address_IN,
    input  write_data_IN,
    output read_data_OUT,
    output valid_OUT,
    output error_OUT,
    output stall_OUT
  );
endinterface

// File: rtl/memory_stage_unit.sv
// Memory stage: owns the 16-bit data memory, runs 16-bit and two-word
// 32-bit accesses and stalls upstream while a wide access is open.
module memory_stage_unit #(
  parameter int ADDR_WIDTH = 11
) (
  input logic                clk,
  input logic                reset,
  memory_stage_unit_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_SECOND
  } state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t r_state;
  state_t w_state_nx;

  logic [15:0] r_mem [0:DEPTH-1];

  logic [31:0]           r_rd_data;
  logic                  r_valid;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_addr2;
  logic [15:0]           r_wdata2;
  logic                  r_is_wr;

  logic                  w_req;
  logic                  w_hi_ok;
  logic                  w_last;
  logic                  w_legal;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [15:0]           w_rdata;

  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [15:0]           w_mem_wdata;
  logic                  w_rd_full;
  logic                  w_rd_hi;
  logic                  w_rd_lo;
  logic                  w_latch;
  logic                  w_valid_nx;
  logic                  w_err_nx;

  assign w_req   = bus.mem_read_IN | bus.mem_write_IN;
  assign w_addr  = bus.address_IN[ADDR_WIDTH-1:0];
  assign w_hi_ok = (bus.address_IN[15:ADDR_WIDTH] == '0);
  // A wide access at the last word would spill past the end of memory.
  assign w_last  = &w_addr;
  assign w_legal = w_hi_ok & ~(bus.mem_wide_IN & w_last);
  assign w_rdata = r_mem[w_mem_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_req & w_legal & bus.mem_wide_IN) begin
          w_state_nx = S_SECOND;
        end
      end
      S_SECOND: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = w_addr;
    w_mem_wdata = bus.write_data_IN[15:0];
    w_rd_full   = 1'b0;
    w_rd_hi     = 1'b0;
    w_rd_lo     = 1'b0;
    w_latch     = 1'b0;
    w_valid_nx  = 1'b0;
    w_err_nx    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_req & ~w_legal) begin
          w_err_nx = 1'b1;
        end else if (w_req & bus.mem_wide_IN) begin
          w_latch = 1'b1;
          if (bus.mem_write_IN) begin
            w_mem_we    = 1'b1;
            w_mem_wdata = bus.write_data_IN[31:16];
          end else begin
            w_rd_hi = 1'b1;
          end
        end else if (w_req) begin
          w_valid_nx = 1'b1;
          if (bus.mem_write_IN) begin
            w_mem_we = 1'b1;
          end else begin
            w_rd_full = 1'b1;
          end
        end
      end
      S_SECOND: begin
        w_mem_addr  = r_addr2;
        w_mem_wdata = r_wdata2;
        w_mem_we    = r_is_wr;
        w_rd_lo     = ~r_is_wr;
        w_valid_nx  = 1'b1;
      end
    endcase
    // Reset aborts a pending second word without touching memory.
    if (reset) begin
      w_mem_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_addr2   <= '0;
      r_wdata2  <= '0;
      r_is_wr   <= 1'b0;
    end else begin
      r_valid <= w_valid_nx;
      r_err   <= w_err_nx;
      if (w_rd_full) begin
        r_rd_data <= {16'h0000, w_rdata};
      end
      if (w_rd_hi) begin
        r_rd_data[31:16] <= w_rdata;
      end
      if (w_rd_lo) begin
        r_rd_data[15:0] <= w_rdata;
      end
      if (w_latch) begin
        r_addr2  <= w_addr + ADDR_WIDTH'(1);
        r_wdata2 <= bus.write_data_IN[15:0];
        r_is_wr  <= bus.mem_write_IN;
      end
    end
  end

  assign bus.read_data_OUT = r_rd_data;
  assign bus.valid_OUT     = r_valid;
  assign bus.error_OUT     = r_err;
  assign bus.stall_OUT     = ~reset & (r_state == S_IDLE) & w_req
                           & bus.mem_wide_IN & w_legal;

endmodule
